// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a length-tagged parallel word out MSB-first with idle gaps.
// Define SEQ_TX_PARITY_EN to append one even-parity bit after each pattern.
module seq_pattern_tx #(
  parameter int   WIDTH      = 16,
  parameter int   LEN_W      = 5,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic [7:0]       pat_cnt
);

`ifdef SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int SW = WIDTH + PB;
  localparam int CW = $clog2(SW + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          state_reg;
  logic [SW-1:0]   sh_reg;
  logic [CW-1:0]   rem_reg;
  logic [GW-1:0]   gap_reg;
  logic            out_reg;
  logic            out_valid_reg;
  logic            last_reg;
  logic [7:0]      pat_cnt_reg;

  logic [LEN_W-1:0] eff_len;
  logic [CW-1:0]    total;
  logic [CW-1:0]    shamt;
  logic [SW-1:0]    data_ext;
  logic [SW-1:0]    aligned;
  logic             start;

  assign eff_len = (in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;

`ifdef SEQ_TX_PARITY_EN
  // Parity covers only the bits that are actually transmitted.
  logic [WIDTH-1:0] masked;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign masked[gi] = in_data[gi] & (LEN_W'(gi) < eff_len);
    end
  endgenerate
  assign data_ext = {in_data, ^masked};
`else
  assign data_ext = in_data;
`endif

  // Left-align so the first bit to send sits at the top of the shift register.
  assign total   = CW'(eff_len) + CW'(PB);
  assign shamt   = CW'(SW) - total;
  assign aligned = data_ext << shamt;

  assign in_ready = arstn && ((state_reg == S_IDLE) ||
                              ((state_reg == S_SHIFT) && last_reg && (GAP_CYCLES == 0)));
  assign start    = in_valid && in_ready && (eff_len != '0);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= S_IDLE;
      sh_reg        <= '0;
      rem_reg       <= '0;
      gap_reg       <= '0;
      out_reg       <= IDLE_BIT;
      out_valid_reg <= 1'b0;
      last_reg      <= 1'b0;
      pat_cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_SHIFT;
            out_reg       <= aligned[SW-1];
            sh_reg        <= aligned << 1;
            rem_reg       <= total - CW'(1);
            last_reg      <= (total == CW'(1));
            out_valid_reg <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (rem_reg != '0) begin
            out_reg  <= sh_reg[SW-1];
            sh_reg   <= sh_reg << 1;
            rem_reg  <= rem_reg - CW'(1);
            last_reg <= (rem_reg == CW'(1));
          end else begin
            pat_cnt_reg <= pat_cnt_reg + 8'd1;
            if (GAP_CYCLES > 0) begin
              state_reg     <= S_GAP;
              gap_reg       <= GAP_INIT;
              out_reg       <= IDLE_BIT;
              out_valid_reg <= 1'b0;
              last_reg      <= 1'b0;
            end else if (start) begin
              // Back-to-back: the next pattern's first bit follows immediately.
              out_reg       <= aligned[SW-1];
              sh_reg        <= aligned << 1;
              rem_reg       <= total - CW'(1);
              last_reg      <= (total == CW'(1));
              out_valid_reg <= 1'b1;
            end else begin
              state_reg     <= S_IDLE;
              out_reg       <= IDLE_BIT;
              out_valid_reg <= 1'b0;
              last_reg      <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_reg == '0) state_reg <= S_IDLE;
          else gap_reg <= gap_reg - GW'(1);
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign last      = last_reg;
  assign pat_cnt   = pat_cnt_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: default-gap instance plus a zero-gap instance for back-to-back.
module tb_seq_pattern_tx;
  logic        clk;
  logic        arstn;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        tx_out, tx_valid, tx_last;
  logic [7:0]  pat_cnt;

  logic        v0, rdy0;
  logic [15:0] d0;
  logic [4:0]  l0;
  logic        o0, ov0, last0;
  logic [7:0]  pc0;

  int vec_cnt = 0;
  int err_cnt = 0;

  seq_pattern_tx dut (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .out(tx_out), .out_valid(tx_valid),
    .last(tx_last), .pat_cnt(pat_cnt)
  );

  seq_pattern_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .arstn(arstn), .in_valid(v0), .in_ready(rdy0),
    .in_data(d0), .in_len(l0), .out(o0), .out_valid(ov0),
    .last(last0), .pat_cnt(pc0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 with in_valid dropped.
  task automatic send(input logic [15:0] data, input logic [4:0] len);
    in_valid = 1'b1;
    in_data  = data;
    in_len   = len;
    $display("send data=%04h len=%0d", data, len);
    check_val("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    in_len   = 5'd7;
  endtask

  task automatic expect_bits(input string tag, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_out%0d", tag, i), {31'd0, tx_out}, {31'd0, bits[n-1-i]});
      check_val($sformatf("%s_vld%0d", tag, i), {31'd0, tx_valid}, 32'd1);
      check_val($sformatf("%s_last%0d", tag, i), {31'd0, tx_last}, (i == n-1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic expect_gap(input string tag, input logic [7:0] pc);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s_gout%0d", tag, i), {31'd0, tx_out}, 32'd0);
      check_val($sformatf("%s_gvld%0d", tag, i), {31'd0, tx_valid}, 32'd0);
      check_val($sformatf("%s_grdy%0d", tag, i), {31'd0, in_ready}, 32'd0);
      check_val($sformatf("%s_gcnt%0d", tag, i), {24'd0, pat_cnt}, {24'd0, pc});
      @(negedge clk);
    end
    check_val({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    arstn    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h000B;
    in_len   = 5'd4;
    v0 = 1'b0; d0 = 16'h0; l0 = 5'd0;
    #1 arstn = 1'b0;

    // Reset held while offering a pattern
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_out", {31'd0, tx_out}, 32'd0);
      check_val("rst_vld", {31'd0, tx_valid}, 32'd0);
      check_val("rst_last", {31'd0, tx_last}, 32'd0);
      check_val("rst_rdy", {31'd0, in_ready}, 32'd0);
      check_val("rst_cnt", {24'd0, pat_cnt}, 32'd0);
    end
    in_valid = 1'b0;
    arstn    = 1'b1;
    #1 check_val("rst_rdy_release", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
    send(16'h000B, 5'd4);
    expect_bits("par", 32'b10111, 5);
    expect_gap("par", 8'd1);
`else
    // Basic 4-bit pattern with default gap
    send(16'h000B, 5'd4);
    expect_bits("basic", 32'b1011, 4);
    expect_gap("basic", 8'd1);

    // Zero length: consumed, nothing sent
    in_valid = 1'b1; in_data = 16'hFFFF; in_len = 5'd0;
    $display("send data=ffff len=0");
    @(negedge clk);
    in_valid = 1'b0;
    check_val("len0_rdy", {31'd0, in_ready}, 32'd1);
    check_val("len0_vld", {31'd0, tx_valid}, 32'd0);
    check_val("len0_cnt", {24'd0, pat_cnt}, 32'd1);
    @(negedge clk);
    check_val("len0_vld2", {31'd0, tx_valid}, 32'd0);

    // Oversized length clamps to 16
    send(16'h8001, 5'd20);
    expect_bits("clamp", 32'h8001, 16);
    expect_gap("clamp", 8'd2);

    // Back-to-back on the zero-gap instance
    v0 = 1'b1; d0 = 16'h000B; l0 = 5'd4;
    $display("send0 data=000b len=4");
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [6:0] b2b;
      b2b = 7'b1011110;
      check_val($sformatf("b2b_out%0d", i), {31'd0, o0}, {31'd0, b2b[6-i]});
      check_val($sformatf("b2b_vld%0d", i), {31'd0, ov0}, 32'd1);
      check_val($sformatf("b2b_last%0d", i), {31'd0, last0}, (i == 3 || i == 6) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check_val("b2b_rdy3", {31'd0, rdy0}, 32'd1);
        v0 = 1'b1; d0 = 16'h0006; l0 = 5'd3;
        $display("send0 data=0006 len=3");
      end else begin
        v0 = 1'b0;
      end
      if (i == 4) check_val("b2b_cnt_mid", {24'd0, pc0}, 32'd1);
      @(negedge clk);
    end
    check_val("b2b_vld_end", {31'd0, ov0}, 32'd0);
    check_val("b2b_cnt", {24'd0, pc0}, 32'd2);

    // Reset during bit 2 of an 8-bit pattern
    send(16'h00FF, 5'd8);
    @(negedge clk);
    @(negedge clk);
    check_val("mid_vld_before", {31'd0, tx_valid}, 32'd1);
    arstn = 1'b0;
    #1;
    check_val("mid_out", {31'd0, tx_out}, 32'd0);
    check_val("mid_vld", {31'd0, tx_valid}, 32'd0);
    check_val("mid_last", {31'd0, tx_last}, 32'd0);
    check_val("mid_rdy", {31'd0, in_ready}, 32'd0);
    check_val("mid_cnt", {24'd0, pat_cnt}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    #1 check_val("mid_rdy_release", {31'd0, in_ready}, 32'd1);
    send(16'h000B, 5'd4);
    expect_bits("after", 32'b1011, 4);
    check_val("after_cnt", {24'd0, pat_cnt}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
